// File: rtl/fx_rx_align.sv
// fx_rx_align: 100BASE-FX receive symbol aligner and 4B5B frame sequencer.
// Hunts the J/K delimiter at any of five bit offsets, then decodes nibbles with MII-style flags.
module fx_rx_align #(
    parameter int unsigned LOSS_CNT = 3
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic [4:0] i_data,
    output logic [3:0] o_nibble,
    output logic       o_rx_dv,
    output logic       o_rx_er,
    output logic       o_locked,
    output logic [2:0] o_offset,
    output logic [7:0] o_err_cnt
);
    localparam int unsigned SYM_W   = 5;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned OFF_W   = 3;
    localparam int unsigned ERR_W   = 8;
    localparam int unsigned BAD_W   = 3;
    localparam int unsigned NUM_OFF = 5;
    localparam int unsigned D2_W    = 4;
    localparam int unsigned WIN_W   = 2 * SYM_W + D2_W;

    localparam logic [SYM_W-1:0] SYM_I = 5'b11111;
    localparam logic [SYM_W-1:0] SYM_J = 5'b11000;
    localparam logic [SYM_W-1:0] SYM_K = 5'b10001;
    localparam logic [SYM_W-1:0] SYM_T = 5'b01101;
    localparam logic [SYM_W-1:0] SYM_R = 5'b00111;

    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_TERM = 2'd3;

    // Oldest history word keeps only the bits the offset-4 previous symbol can reach.
    logic [SYM_W-1:0] d0_q;
    logic [SYM_W-1:0] d1_q;
    logic [D2_W-1:0]  d2_q;

    logic [1:0]       state_q;
    logic [1:0]       state_n;
    logic [BAD_W-1:0] bad_q;
    logic [BAD_W-1:0] bad_n;

    logic [NIB_W-1:0] nibble_n;
    logic             dv_n;
    logic             er_n;
    logic             locked_n;
    logic [OFF_W-1:0] offset_n;
    logic [ERR_W-1:0] err_n;
    logic             err_bump_c;

    logic [WIN_W-1:0] win_c;
    logic [SYM_W-1:0] sym_c [NUM_OFF];
    logic [SYM_W-1:0] prv_c [NUM_OFF];
    logic             hit_c;
    logic [OFF_W-1:0] hit_off_c;
    logic [SYM_W-1:0] cur_c;
    logic             data_c;
    logic [NIB_W-1:0] nib_c;

    // Slice aligned/previous symbols per offset; lowest offset with a J/K pair wins.
    always_comb begin
        win_c     = {d2_q, d1_q, d0_q};
        hit_c     = 1'b0;
        hit_off_c = '0;
        for (int k = 0; k < int'(NUM_OFF); k++) begin
            sym_c[k] = win_c[4+k -: 5];
            prv_c[k] = win_c[9+k -: 5];
            if (!hit_c && prv_c[k] == SYM_J && sym_c[k] == SYM_K) begin
                hit_c     = 1'b1;
                hit_off_c = OFF_W'(k);
            end
        end
    end

    // Symbol at the locked offset.
    always_comb begin
        cur_c = sym_c[0];
        case (o_offset)
            3'd1:    cur_c = sym_c[1];
            3'd2:    cur_c = sym_c[2];
            3'd3:    cur_c = sym_c[3];
            3'd4:    cur_c = sym_c[4];
            default: cur_c = sym_c[0];
        endcase
    end

    // 4B5B data code to nibble.
    always_comb begin
        data_c = 1'b1;
        nib_c  = '0;
        case (cur_c)
            5'b11110: nib_c = 4'h0;
            5'b01001: nib_c = 4'h1;
            5'b10100: nib_c = 4'h2;
            5'b10101: nib_c = 4'h3;
            5'b01010: nib_c = 4'h4;
            5'b01011: nib_c = 4'h5;
            5'b01110: nib_c = 4'h6;
            5'b01111: nib_c = 4'h7;
            5'b10010: nib_c = 4'h8;
            5'b10011: nib_c = 4'h9;
            5'b10110: nib_c = 4'hA;
            5'b10111: nib_c = 4'hB;
            5'b11010: nib_c = 4'hC;
            5'b11011: nib_c = 4'hD;
            5'b11100: nib_c = 4'hE;
            5'b11101: nib_c = 4'hF;
            default:  data_c = 1'b0;
        endcase
    end

    // Sequencer next state and next registered outputs.
    always_comb begin
        state_n    = state_q;
        bad_n      = bad_q;
        locked_n   = o_locked;
        offset_n   = o_offset;
        nibble_n   = '0;
        dv_n       = 1'b0;
        er_n       = 1'b0;
        err_bump_c = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (hit_c) begin
                    offset_n = hit_off_c;
                    locked_n = 1'b1;
                    bad_n    = '0;
                    state_n  = ST_DATA;
                end
            end
            ST_IDLE: begin
                if (hit_c) begin
                    offset_n = hit_off_c;
                    bad_n    = '0;
                    state_n  = ST_DATA;
                end else if (cur_c == SYM_I || cur_c == SYM_J) begin
                    bad_n = '0;
                end else if (bad_q == BAD_W'(LOSS_CNT - 1)) begin
                    bad_n    = '0;
                    locked_n = 1'b0;
                    state_n  = ST_HUNT;
                end else begin
                    bad_n = bad_q + BAD_W'(1);
                end
            end
            ST_DATA: begin
                if (data_c) begin
                    nibble_n = nib_c;
                    dv_n     = 1'b1;
                end else if (cur_c == SYM_T) begin
                    state_n = ST_TERM;
                end else if (cur_c == SYM_I) begin
                    er_n       = 1'b1;
                    err_bump_c = 1'b1;
                    state_n    = ST_IDLE;
                end else begin
                    dv_n       = 1'b1;
                    er_n       = 1'b1;
                    err_bump_c = 1'b1;
                end
            end
            ST_TERM: begin
                state_n = ST_IDLE;
                if (cur_c != SYM_R) begin
                    er_n       = 1'b1;
                    err_bump_c = 1'b1;
                end
            end
            default: state_n = ST_HUNT;
        endcase
        err_n = (err_bump_c && o_err_cnt != '1) ? o_err_cnt + ERR_W'(1) : o_err_cnt;
    end

    // State, history and output registers.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            d0_q      <= '1;
            d1_q      <= '1;
            d2_q      <= '1;
            state_q   <= ST_HUNT;
            bad_q     <= '0;
            o_nibble  <= '0;
            o_rx_dv   <= 1'b0;
            o_rx_er   <= 1'b0;
            o_locked  <= 1'b0;
            o_offset  <= '0;
            o_err_cnt <= '0;
        end else begin
            d0_q      <= i_data;
            d1_q      <= d0_q;
            d2_q      <= d1_q[D2_W-1:0];
            state_q   <= state_n;
            bad_q     <= bad_n;
            o_nibble  <= nibble_n;
            o_rx_dv   <= dv_n;
            o_rx_er   <= er_n;
            o_locked  <= locked_n;
            o_offset  <= offset_n;
            o_err_cnt <= err_n;
        end
    end

endmodule
